// File: rtl/input_debounce_if.sv
// Signal bundle between the raw switch inputs and the debounced consumer side.
// master drives the raw inputs; slave is the debouncer.
interface input_debounce_if;
    logic a_raw;
    logic b_raw;
    logic a;
    logic b;
    logic stable;
    logic a_rise;
    logic a_fall;
    logic b_rise;
    logic b_fall;

    modport master (
        output a_raw, b_raw,
        input  a, b, stable, a_rise, a_fall, b_rise, b_fall
    );

    modport slave (
        input  a_raw, b_raw,
        output a, b, stable, a_rise, a_fall, b_rise, b_fall
    );
endinterface

// File: rtl/input_debounce.sv
// Two-channel debouncer: 2-flop sync, per-channel settle FSM and counter, registered outputs.
// Define INPUT_DEBOUNCE_EDGE_EN to generate the registered a/b rise/fall pulses.
//   state       | meaning
//   ST_STABLE   | synchronized input equals debounced output, counter idle at 0
//   ST_SETTLING | input differs from output, counting consecutive mismatch cycles
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input_debounce_if.slave  bus
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [1:0]       out_q, out_d;
    logic             stable_q, stable_d;
    state_e           state_q [2];
    state_e           state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];

    always_comb begin
        s1_d = {bus.b_raw, bus.a_raw};
        s2_d = s1_q;
        out_d = out_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    cnt_d[i] = '0;
                    if (s2_q[i] != out_q[i]) begin
                        // A single-cycle debounce needs no settling phase.
                        if (DEBOUNCE_CYCLES == 1) begin
                            out_d[i] = s2_q[i];
                        end else begin
                            state_d[i] = ST_SETTLING;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                ST_SETTLING: begin
                    if (s2_q[i] == out_q[i]) begin
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        out_d[i]   = s2_q[i];
                        state_d[i] = ST_STABLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
        stable_d = (state_d[0] == ST_STABLE) && (state_d[1] == ST_STABLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            out_q    <= '0;
            stable_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            out_q    <= out_d;
            stable_q <= stable_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign bus.a      = out_q[0];
    assign bus.b      = out_q[1];
    assign bus.stable = stable_q;

`ifdef INPUT_DEBOUNCE_EDGE_EN
    logic [1:0] rise_q, rise_d;
    logic [1:0] fall_q, fall_d;

    // Pulses register alongside out_q so they line up with the output change.
    always_comb begin
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign bus.a_rise = rise_q[0];
    assign bus.a_fall = fall_q[0];
    assign bus.b_rise = rise_q[1];
    assign bus.b_fall = fall_q[1];
`else
    assign bus.a_rise = 1'b0;
    assign bus.a_fall = 1'b0;
    assign bus.b_rise = 1'b0;
    assign bus.b_fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: expected per-edge values are queued as stimulus is
// applied and compared once the edge has happened. A second instance runs DEBOUNCE_CYCLES=1.
module tb_input_debounce;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    input_debounce_if dif ();
    input_debounce_if dif1 ();

    input_debounce u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    input_debounce #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (dif1)
    );

`ifdef INPUT_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    typedef struct {
        logic a, b, stable, a_rise, a_fall, b_rise, b_fall;
        bit   chk1;
        logic a1;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input logic a, input logic b, input logic s,
                                input logic ar, input logic af,
                                input logic br, input logic bf,
                                input bit c1 = 1'b0, input logic a1 = 1'b0);
        exp_t e;
        e.a = a; e.b = b; e.stable = s;
        e.a_rise = ar; e.a_fall = af; e.b_rise = br; e.b_fall = bf;
        e.chk1 = c1; e.a1 = a1;
        return e;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive inputs for one edge, queue its expectation, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic ra, input logic rb,
                        input exp_t e);
        exp_t got;
        rst = r;
        dif.a_raw  = ra;
        dif.b_raw  = rb;
        dif1.a_raw = ra;
        dif1.b_raw = rb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            got = exp_q.pop_front();
            check({tag, "_a"},      dif.a,         got.a);
            check({tag, "_b"},      dif.b,         got.b);
            check({tag, "_stable"}, dif.stable,    got.stable);
            check({tag, "_a_rise"}, dif.a_rise,    got.a_rise);
            check({tag, "_a_fall"}, dif.a_fall,    got.a_fall);
            check({tag, "_b_rise"}, dif.b_rise,    got.b_rise);
            check({tag, "_b_fall"}, dif.b_fall,    got.b_fall);
            check({tag, "_gate"},   dif.a & dif.b, got.a & got.b);
            if (got.chk1) begin
                check({tag, "_d1_a"},      dif1.a,      got.a1);
                check({tag, "_d1_stable"}, dif1.stable, 1'b1);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        dif.a_raw = 1'b0;  dif.b_raw = 1'b0;
        dif1.a_raw = 1'b0; dif1.b_raw = 1'b0;

        for (int i = 1; i <= 2; i++)
            step("reset", 1'b1, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0));

        // 3-cycle glitch never reaches the output
        for (int i = 1; i <= 8; i++)
            step("glitch", 1'b0, i <= 3, 1'b0,
                 mk(0, 0, !(i >= 3 && i <= 5), 0, 0, 0, 0));

        for (int i = 1; i <= 10; i++)
            step("press", 1'b0, 1'b1, 1'b0,
                 mk(i >= 6, 0, !(i >= 3 && i <= 5), EDGE_EN && i == 6, 0, 0, 0,
                    1'b1, i >= 3));

        for (int i = 1; i <= 10; i++)
            step("release", 1'b0, 1'b0, 1'b0,
                 mk(i < 6, 0, !(i >= 3 && i <= 5), 0, EDGE_EN && i == 6, 0, 0,
                    1'b1, i < 3));

        for (int i = 1; i <= 10; i++)
            step("simul", 1'b0, 1'b1, 1'b1,
                 mk(i >= 6, i >= 6, !(i >= 3 && i <= 5),
                    EDGE_EN && i == 6, 0, EDGE_EN && i == 6, 0));

        for (int i = 1; i <= 10; i++)
            step("rel_a", 1'b0, 1'b0, 1'b1,
                 mk(i < 6, 1, !(i >= 3 && i <= 5), 0, EDGE_EN && i == 6, 0, 0));

        // Raw 1,1,0 then held 1: count restarts, output rises 6 edges after the last run starts
        for (int i = 1; i <= 12; i++)
            step("bounce", 1'b0, i != 3, 1'b1,
                 mk(i >= 9, 1, !(i inside {3, 4, 6, 7, 8}), EDGE_EN && i == 9, 0, 0, 0));

        for (int i = 1; i <= 2; i++)
            step("reset2", 1'b1, 1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0, 0));

        for (int i = 1; i <= 3; i++)
            step("mid_pre", 1'b0, 1'b1, 1'b0, mk(0, 0, i < 3, 0, 0, 0, 0));
        step("mid_rst", 1'b1, 1'b1, 1'b0, mk(0, 0, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 10; i++)
            step("mid_post", 1'b0, 1'b1, 1'b0,
                 mk(i >= 6, 0, !(i >= 3 && i <= 5), EDGE_EN && i == 6, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive cycles a synchronized input must hold a new level before the output follows it; legal range 1..2^CNT_W.
REQ-002 Parameter CNT_W, default 16: settle-counter width in bits; it SHALL hold DEBOUNCE_CYCLES-1.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port a_raw, input, 1: asynchronous bouncy input, channel A.
REQ-006 Port b_raw, input, 1: asynchronous bouncy input, channel B.
REQ-007 Port a, output, 1: debounced channel A level; drives the downstream gate's a input.
REQ-008 Port b, output, 1: debounced channel B level; drives the downstream gate's b input.
REQ-009 Port stable, output, 1: high when neither channel is settling.
REQ-010 Ports a_rise, a_fall, b_rise, b_fall, output, 1 each: one-cycle edge pulses of a and b.

Function
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Each channel SHALL run an independent 2-state FSM, STABLE and SETTLING, with a CNT_W-bit counter.
- STABLE: s2 == output; counter held at 0. If s2 != output, go to SETTLING and set counter to 1, except when DEBOUNCE_CYCLES == 1: update the output immediately and stay in STABLE.
- SETTLING: if s2 == output (bounce back), return to STABLE and clear the counter. If s2 != output and counter == DEBOUNCE_CYCLES-1, the output takes s2, the counter clears and the FSM goes to STABLE. Otherwise the counter increments.
REQ-013 Latency: take edge 1 as the first rising edge sampling a new raw level that then holds. The output changes on edge DEBOUNCE_CYCLES+2 (edge 6 for the default of 4).
REQ-014 Any return of s2 to the current output level during SETTLING SHALL restart the count from the next mismatch; there is no partial credit.
REQ-015 The counter SHALL never wrap; it is bounded by DEBOUNCE_CYCLES-1.
REQ-016 The two channels SHALL be fully independent; simultaneous transitions on both settle in parallel with identical latency.
REQ-017 stable SHALL be registered and equal to (A FSM == STABLE) AND (B FSM == STABLE) after each edge.
REQ-018 The outputs a and b SHALL be registered, with no combinational path from raw inputs to any output.

Reset
REQ-019 While rst is high at a rising edge: s1, s2, counters, a, b and all edge pulses clear to 0; both FSMs go to STABLE; stable goes to 1.
REQ-020 Reset asserted mid-SETTLING SHALL discard the pending transition, and the output remains 0.
REQ-021 After rst deasserts, a raw input held high SHALL produce an output rise on edge DEBOUNCE_CYCLES+2, counted from the first non-reset edge.

Configuration
REQ-022 Macro INPUT_DEBOUNCE_EDGE_EN defined: on the edge where a goes 0->1, a_rise is high for exactly one cycle. a_fall, b_rise and b_fall behave the same way for their edges. All pulses are registered and aligned with the output change.
REQ-023 Macro INPUT_DEBOUNCE_EDGE_EN undefined: the edge-pulse ports SHALL remain present and tied to constant 0, and no edge-detection logic is generated.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 Glitch: a_raw high for 3 cycles, then low -> a stays 0, stable returns to 1, no a_rise.
REQ-025 Clean press: a_raw rises and holds 10 cycles -> a rises on edge 6; a_rise is a single pulse on edge 6 (macro defined) or stays 0 (macro undefined).
REQ-026 Bounce: a_raw pattern 1,1,0,1,1,1,1 -> count restarts after the 0; a rises 6 edges after the final 1-run begins.
REQ-027 Simultaneous: a_raw and b_raw rise on the same cycle -> a and b rise on the same edge 6; stable is low on edges 3-5 and returns high on edge 6.
REQ-028 Reset mid-settle: a_raw held high, rst pulsed on edge 4 -> a stays 0; a rises on the 6th edge after rst deasserts.
REQ-029 Release: a=1, a_raw falls and holds -> a falls on edge 6 with a_fall pulse; downstream AND output follows a&b.
